// File: rtl/data_pack_if.sv
// Symbol-in / word-out stream bundle for the data_pack bit packer.
// The slave modport is the packer's own view; master is the environment
// (upstream symbol source plus downstream word sink).
interface data_pack_if;
  logic [6:0]  data_in;
  logic        sop_in;
  logic        eop_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic [5:0]  bits_out;
  logic        valid_out;
  logic        ready_in;
  logic        err_out;

  modport slave (
    input  data_in, sop_in, eop_in, valid_in, ready_in,
    output ready_out, data_out, sop_out, eop_out, bits_out, valid_out, err_out
  );

  modport master (
    output data_in, sop_in, eop_in, valid_in, ready_in,
    input  ready_out, data_out, sop_out, eop_out, bits_out, valid_out, err_out
  );
endinterface

// File: rtl/data_pack.sv
// data_pack: repacks 7-bit symbols LSB-first into 32-bit words with packet
// framing. The last word of a packet is zero-padded and reports its count
// of valid bits; an overflowing last symbol spills into one extra FLUSH word.
module data_pack (
  input  logic         clk,
  input  logic         rst,
  data_pack_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t      state;
  logic [37:0] acc;
  logic [5:0]  cnt;
  logic        first;

  logic        accept;
  logic        start;
  logic [37:0] base_acc;
  logic [5:0]  base_cnt;
  logic        base_first;
  logic [37:0] pack_new;
  logic [5:0]  pack_n;

  // FLUSH owns the output stage for one word, so no symbol may enter then.
  assign bus.ready_out = (state != FLUSH) && (!bus.valid_out || bus.ready_in);
  assign accept        = bus.valid_in && bus.ready_out;
  assign start         = accept && bus.sop_in;

  // Merge the incoming symbol into the accumulator; a sop starts from empty.
  always_comb begin
    base_acc   = start ? 38'd0 : acc;
    base_cnt   = start ? 6'd0  : cnt;
    base_first = start ? 1'b1  : first;
    pack_new   = base_acc | ({31'd0, bus.data_in} << base_cnt);
    pack_n     = base_cnt + 6'd7;
  end

  // Packer FSM with the registered output stage and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      first         <= 1'b0;
      bus.data_out  <= '0;
      bus.sop_out   <= 1'b0;
      bus.eop_out   <= 1'b0;
      bus.bits_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.err_out   <= 1'b0;
    end else begin
      bus.err_out <= 1'b0;
      // A transferred word leaves unless overwritten by a load below.
      if (bus.valid_out && bus.ready_in) begin
        bus.valid_out <= 1'b0;
      end

      case (state)
        IDLE, PACK: begin
          // In IDLE only a sop symbol is meaningful; others are dropped.
          if (accept && (state == PACK || bus.sop_in)) begin
            if (state == PACK && bus.sop_in) begin
              bus.err_out <= 1'b1;
            end
            if (pack_n >= 6'd32) begin
              bus.data_out  <= pack_new[31:0];
              bus.bits_out  <= 6'd32;
              bus.sop_out   <= base_first;
              bus.eop_out   <= bus.eop_in && (pack_n == 6'd32);
              bus.valid_out <= 1'b1;
              acc           <= pack_new >> 32;
              cnt           <= pack_n - 6'd32;
              first         <= 1'b0;
              if (bus.eop_in) begin
                state <= (pack_n == 6'd32) ? IDLE : FLUSH;
              end else begin
                state <= PACK;
              end
            end else if (bus.eop_in) begin
              bus.data_out  <= pack_new[31:0];
              bus.bits_out  <= pack_n;
              bus.sop_out   <= base_first;
              bus.eop_out   <= 1'b1;
              bus.valid_out <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
              first         <= 1'b0;
              state         <= IDLE;
            end else begin
              acc   <= pack_new;
              cnt   <= pack_n;
              first <= base_first;
              state <= PACK;
            end
          end
        end

        FLUSH: begin
          // Emit the 1..6 spilled bits as the packet's final word.
          if (!bus.valid_out || bus.ready_in) begin
            bus.data_out  <= acc[31:0];
            bus.bits_out  <= cnt;
            bus.sop_out   <= 1'b0;
            bus.eop_out   <= 1'b1;
            bus.valid_out <= 1'b1;
            acc           <= '0;
            cnt           <= '0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
